pm_boot_loader_ctrl: RTL

- Boot/load sequencer between the TinyTapeout pin interface and the pipelined RISC-V CPU's program memory.
- Collects DATA_WIDTH/WIDTH byte strobes from the 8-bit input pins and assembles them into instruction words.
- Writes each word to program memory at an auto-incrementing address.
- Holds the CPU in reset while loading; releases it with a fixed hold delay once loading ends.

---
 rtl/pm_boot_loader_ctrl_if.sv | 29 ++
 rtl/pm_boot_loader_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pm_boot_loader_ctrl_if.sv
// Pin-side and program-memory-side signal bundle of the boot loader.
interface pm_boot_loader_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 7,
    parameter int unsigned WIDTH      = 8
);
    logic                  load_en;
    logic                  byte_stb;
    logic [WIDTH-1:0]      byte_in;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_wdata;
    logic                  cpu_rst_n;
    logic                  busy;
    logic [ADD_WIDTH:0]    word_count;
    logic                  overflow;

    // Host / environment view: drives the pins, observes memory and CPU side.
    modport master (
        output load_en, byte_stb, byte_in,
        input  pm_wr_en, pm_addr, pm_wdata, cpu_rst_n, busy, word_count, overflow
    );

    // Loader view.
    modport slave (
        input  load_en, byte_stb, byte_in,
        output pm_wr_en, pm_addr, pm_wdata, cpu_rst_n, busy, word_count, overflow
    );
endinterface

// File: rtl/pm_boot_loader_ctrl.sv
// Boot/load sequencer: assembles pin bytes into instruction words, writes them
// to program memory and holds the CPU in reset while loading.
module pm_boot_loader_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 7,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pm_boot_loader_ctrl_if.slave bus
);
    localparam int unsigned LANES  = DATA_WIDTH / WIDTH;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(RST_HOLD + 1);
    localparam logic [ADD_WIDTH:0] WC_FULL = {1'b1, {ADD_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      hold_cnt_q;
    logic [LANE_W-1:0]     lane_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  pm_wr_en_q;
    logic [ADD_WIDTH-1:0]  pm_addr_q;
    logic [DATA_WIDTH-1:0] pm_wdata_q;
    logic                  cpu_rst_n_q;
    logic                  busy_q;
    logic [ADD_WIDTH:0]    word_count_q;
    logic                  overflow_q;

    logic ld_s1_q, ld_s2_q, ld_d_q;
    logic stb_s1_q, stb_s2_q, stb_d_q;

    logic                  ld_rise_c;
    logic                  ld_fall_c;
    logic                  stb_rise_c;
    logic [DATA_WIDTH-1:0] word_next_c;

    assign ld_rise_c  = ld_s2_q & ~ld_d_q;
    assign ld_fall_c  = ~ld_s2_q & ld_d_q;
    assign stb_rise_c = stb_s2_q & ~stb_d_q;

    // Current word with the incoming byte merged into the active lane (LSB first).
    always_comb begin
        word_next_c = word_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                word_next_c[i*WIDTH +: WIDTH] = bus.byte_in;
            end
        end
    end

    // Synchronizers, HOLD/RUN/LOAD sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_s1_q      <= 1'b0;
            ld_s2_q      <= 1'b0;
            ld_d_q       <= 1'b0;
            stb_s1_q     <= 1'b0;
            stb_s2_q     <= 1'b0;
            stb_d_q      <= 1'b0;
            state_q      <= ST_HOLD;
            hold_cnt_q   <= CNT_W'(RST_HOLD);
            lane_q       <= '0;
            word_q       <= '0;
            pm_wr_en_q   <= 1'b0;
            pm_addr_q    <= '0;
            pm_wdata_q   <= '0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            ld_s1_q  <= bus.load_en;
            ld_s2_q  <= ld_s1_q;
            ld_d_q   <= ld_s2_q;
            stb_s1_q <= bus.byte_stb;
            stb_s2_q <= stb_s1_q;
            stb_d_q  <= stb_s2_q;

            pm_wr_en_q <= 1'b0;
            // Address and count advance only after the pulse has presented them.
            if (pm_wr_en_q) begin
                pm_addr_q    <= pm_addr_q + ADD_WIDTH'(1);
                word_count_q <= word_count_q + (ADD_WIDTH + 1)'(1);
            end

            unique case (state_q)
                ST_HOLD: begin
                    if (ld_rise_c) begin
                        state_q      <= ST_LOAD;
                        pm_addr_q    <= '0;
                        lane_q       <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        cpu_rst_n_q  <= 1'b0;
                    end else if (hold_cnt_q <= CNT_W'(1)) begin
                        state_q     <= ST_RUN;
                        hold_cnt_q  <= '0;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (ld_rise_c) begin
                        state_q      <= ST_LOAD;
                        pm_addr_q    <= '0;
                        lane_q       <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        cpu_rst_n_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_fall_c) begin
                        // Exit wins over a coincident byte; partial word dropped.
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= CNT_W'(RST_HOLD);
                        busy_q     <= 1'b0;
                        lane_q     <= '0;
                    end else if (stb_rise_c) begin
                        word_q <= word_next_c;
                        if (lane_q == LANE_W'(LANES - 1)) begin
                            lane_q <= '0;
                            if (word_count_q < WC_FULL) begin
                                pm_wr_en_q <= 1'b1;
                                pm_wdata_q <= word_next_c;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.pm_wr_en   = pm_wr_en_q;
    assign bus.pm_addr    = pm_addr_q;
    assign bus.pm_wdata   = pm_wdata_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.busy       = busy_q;
    assign bus.word_count = word_count_q;
    assign bus.overflow   = overflow_q;
endmodule
